rf_wb_queue: RTL and testbench

//  Write-back queue directly upstream of the register file write port (A3/WD3/WE).

---
 rtl/rf_wb_queue.sv | 102 ++++++++++
 tb/tb_rf_wb_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_queue.sv
// In-order write-back queue feeding the register file write port (A3/WD3/WE).
// Define RF_WB_FWD_EN to add chk_data (youngest pending value for chk_addr).
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic [AW-1:0] lsu_rd,
    input  logic [DW-1:0] lsu_data,
    output logic [AW-1:0] A3,
    output logic [DW-1:0] WD3,
    output logic          WE,
    input  logic [AW-1:0] chk_addr,
`ifdef RF_WB_FWD_EN
    output logic [DW-1:0] chk_data,
`endif
    output logic          chk_busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] rd_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          lsu_push;
    logic          alu_push;
    logic          pop;
    logic [PW-1:0] alu_slot;
    logic [PW-1:0] scan_idx;
    logic          busy_c;
    logic [DW-1:0] fwd_c;

    assign lsu_ready = (count < CW'(DEPTH));
    assign alu_ready = (count <= CW'(DEPTH - 2));

    // Register-0 writes handshake normally but never occupy a slot.
    assign lsu_push  = lsu_valid & lsu_ready & (lsu_rd != '0);
    assign alu_push  = alu_valid & alu_ready & (alu_rd != '0);
    assign pop       = (count != '0);
    assign alu_slot  = wr_ptr + PW'(lsu_push);

    assign WE  = pop;
    assign A3  = rd_mem[rd_ptr];
    assign WD3 = data_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (lsu_push) begin
                rd_mem[wr_ptr]   <= lsu_rd;
                data_mem[wr_ptr] <= lsu_data;
            end
            if (alu_push) begin
                rd_mem[alu_slot]   <= alu_rd;
                data_mem[alu_slot] <= alu_data;
            end
            wr_ptr <= wr_ptr + PW'(lsu_push) + PW'(alu_push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(lsu_push) + CW'(alu_push) - CW'(pop);
        end
    end

    // Scan oldest to youngest so the last match is the youngest entry.
    always_comb begin
        busy_c   = 1'b0;
        fwd_c    = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && (chk_addr != '0) && (rd_mem[scan_idx] == chk_addr)) begin
                busy_c = 1'b1;
                fwd_c  = data_mem[scan_idx];
            end
        end
    end

    assign chk_busy = busy_c;
`ifdef RF_WB_FWD_EN
    assign chk_data = fwd_c;
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_c;
`endif
endmodule

// File: tb/tb_rf_wb_queue.sv
// Randomized bench for rf_wb_queue against a queue-based reference model,
// plus directed cases with literal expectations.
module tb_rf_wb_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, lsu_valid;
    logic          alu_ready, lsu_ready;
    logic [AW-1:0] alu_rd, lsu_rd, chk_addr, A3;
    logic [DW-1:0] alu_data, lsu_data, WD3;
    logic          WE, chk_busy;
`ifdef RF_WB_FWD_EN
    logic [DW-1:0] chk_data;
`endif

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    rf_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .A3        (A3),
        .WD3       (WD3),
        .WE        (WE),
        .chk_addr  (chk_addr),
`ifdef RF_WB_FWD_EN
        .chk_data  (chk_data),
`endif
        .chk_busy  (chk_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        alu_rd = '0; lsu_rd = '0; alu_data = '0; lsu_data = '0;
    endtask

    // Compare DUT outputs with the model, then advance the model across the edge.
    task automatic step();
        int n;
        logic          exp_busy;
        logic [DW-1:0] exp_fwd;
        logic          lr, ar;
        @(negedge clk);
        n  = q.size();
        lr = (n < DEPTH);
        ar = (n <= DEPTH - 2);
        exp_busy = 1'b0;
        exp_fwd  = '0;
        foreach (q[i]) begin
            if (chk_addr != 0 && q[i].rd == chk_addr) begin
                exp_busy = 1'b1;
                exp_fwd  = q[i].data;
            end
        end
        chk("WE", 32'(WE), 32'(n != 0));
        if (n != 0) begin
            chk("A3", 32'(A3), 32'(q[0].rd));
            chk("WD3", WD3, q[0].data);
        end
        chk("lsu_ready", 32'(lsu_ready), 32'(lr));
        chk("alu_ready", 32'(alu_ready), 32'(ar));
        chk("chk_busy", 32'(chk_busy), 32'(exp_busy));
`ifdef RF_WB_FWD_EN
        chk("chk_data", chk_data, exp_fwd);
`endif
        if (n != 0) void'(q.pop_front());
        if (!reset) begin
            if (lsu_valid && lr && lsu_rd != 0) q.push_back('{rd: lsu_rd, data: lsu_data});
            if (alu_valid && ar && alu_rd != 0) q.push_back('{rd: alu_rd, data: alu_data});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        chk_addr = '0;
        idle();
        #12;
        // Reset state
        chk("rst_WE", 32'(WE), 32'd0);
        chk("rst_A3", 32'(A3), 32'd0);
        chk("rst_WD3", WD3, 32'd0);
        chk("rst_chk_busy", 32'(chk_busy), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: idle
        for (int a = 0; a < 4; a++) begin
            chk_addr = AW'(a * 7);
            #1;
            chk("t1_busy", 32'(chk_busy), 32'd0);
        end
        chk("t1_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("t1_alu_ready", 32'(alu_ready), 32'd1);
        step();

        // 2: single ALU write
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hAAAAAAAA;
        step();
        idle();
        chk("t2_WE", 32'(WE), 32'd1);
        chk("t2_A3", 32'(A3), 32'd7);
        chk("t2_WD3", WD3, 32'hAAAAAAAA);
        step();
        chk("t2_WE_off", 32'(WE), 32'd0);

        // 3: simultaneous LSU + ALU, LSU first
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h0000FFFF;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h111105FA;
        step();
        idle();
        chk("t3_A3_0", 32'(A3), 32'd6);
        chk("t3_WD3_0", WD3, 32'h0000FFFF);
        step();
        chk("t3_WE_1", 32'(WE), 32'd1);
        chk("t3_A3_1", 32'(A3), 32'd7);
        chk("t3_WD3_1", WD3, 32'h111105FA);
        step();
        chk("t3_WE_off", 32'(WE), 32'd0);

        // 4: dual pushes build the queue up to DEPTH-1
        for (int i = 0; i < 3; i++) begin
            lsu_valid = 1'b1; lsu_rd = AW'(i + 1);  lsu_data = 32'h100 + 32'(i);
            alu_valid = 1'b1; alu_rd = AW'(i + 10); alu_data = 32'h200 + 32'(i);
            step();
        end
        chk("t4_alu_ready_cnt3", 32'(alu_ready), 32'd0);
        chk("t4_lsu_ready_cnt3", 32'(lsu_ready), 32'd1);
        idle();
        for (int i = 0; i < 4; i++) step();
        chk("t4_drained", 32'(WE), 32'd0);

        // 5: register 0 is accepted but discarded
        alu_valid = 1'b1; alu_rd = '0; alu_data = 32'h11111111;
        #1;
        chk("t5_alu_ready", 32'(alu_ready), 32'd1);
        step();
        idle();
        chk("t5_WE", 32'(WE), 32'd0);
        step();

        // 6: duplicate rd, youngest forwarded, then mid-drain reset
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'd5;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'd9;
        chk_addr = 5'd7;
        step();
        idle();
        #1;
        chk("t6_busy", 32'(chk_busy), 32'd1);
`ifdef RF_WB_FWD_EN
        chk("t6_fwd", chk_data, 32'd9);
`endif
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_WE", 32'(WE), 32'd0);
        chk("t6_rst_busy", 32'(chk_busy), 32'd0);
        q.delete();
        step();
        reset = 1'b0;
        step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            lsu_valid = ($urandom_range(0, 99) < 60);
            alu_valid = ($urandom_range(0, 99) < 60);
            lsu_rd    = AW'($urandom_range(0, 7));
            alu_rd    = AW'($urandom_range(0, 7));
            lsu_data  = $urandom;
            alu_data  = $urandom;
            chk_addr  = AW'($urandom_range(0, 7));
            if (c == 1500) begin
                #2;
                reset = 1'b1;
                #1;
                chk("rnd_rst_WE", 32'(WE), 32'd0);
                q.delete();
                idle();
                step();
                reset = 1'b0;
            end else begin
                step();
            end
        end
        idle();
        for (int i = 0; i < DEPTH + 2; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
